pciexp_tx_sched: RTL and testbench
==================================

Name: pciexp_tx_sched

Overview:
- Symbol scheduler in front of the PCIe transmit encoder path.
- Arbitrates, one byte symbol per PCLK250 cycle, between link-layer packet bytes, SKP ordered-set insertion, Electrical Idle ordered set (EIOS) entry, the compliance pattern, and logical idle filler.
- Drives the TXDATA/TXDATAK/TXELECIDLE/TXCOMPLIANCE inputs of the transmit datapath.

Parameters:
- SKP_INTERVAL, 1180, symbol times between SKP ordered-set requests; legal range 16..4095; counter width 12 bits.

Ports:
- PCLK250  in  1  symbol clock, 250 MHz.
- RESET  in  1  asynchronous, active-high reset.
- LTSSM_ElecIdleReq_P0  in  1  level; request electrical idle.
- CNTL_Compliance_P0  in  1  level; request compliance pattern.
- DL_Valid_P0  in  1  link-layer symbol valid.
- DL_Data_P0  in  8  link-layer symbol.
- DL_DataK_P0  in  1  link-layer K flag.
- DL_Eop_P0  in  1  marks the last symbol of a packet.
- DL_Ready  out  1  symbol accepted when Valid & Ready.
- TXDATA  out  8  scheduled symbol, registered.
- TXDATAK  out  1  K flag, registered.
- TXELECIDLE  out  1  electrical idle, registered.
- TXCOMPLIANCE  out  1  compliance negative-disparity flag, registered.
- SkpSent  out  1  one-cycle pulse on the last SKP symbol.
- Underrun  out  1  one-cycle pulse when DL_Valid is low mid-packet.

Behaviour:
- Reset (asynchronous, RESET=1):
  - State EIDLE.
  - TXELECIDLE=1; TXDATA=8'h00, TXDATAK=0, TXCOMPLIANCE=0, DL_Ready=0, SkpSent=0, Underrun=0.
  - SKP counter=0, skp_pending=0, in_pkt=0.
  - Assertion mid-sequence aborts any SKP/EIOS/packet immediately; no completion.
- Latency: a symbol chosen in cycle N appears on TX* at cycle N+1. All outputs are registered except DL_Ready, which is combinational from state.
- States: EIDLE, IDLE, DATA, SKP, EIOS, COMPL. SKP, EIOS and COMPL use a 2-bit symbol index.
- Boundary: cycle in IDLE, or in DATA with in_pkt=0.
- Boundary priority: skp_pending > LTSSM_ElecIdleReq_P0 > CNTL_Compliance_P0 > DL_Valid_P0 > logical idle.
- Logical idle symbol: 8'h00, K=0.
- DL_Ready=1 only in IDLE/DATA when at a boundary with no higher-priority request pending, or when in_pkt=1.
- Packet handling:
  - An accepted symbol with DL_Eop_P0=0 sets in_pkt; an accepted symbol with DL_Eop_P0=1 clears it.
  - While in_pkt=1, SKP/EIOS/compliance are deferred.
  - DL_Valid_P0=0 while in_pkt=1 sends logical idle and pulses Underrun; in_pkt stays 1.
- EIDLE:
  - TXELECIDLE=1, TXDATA=0.
  - Leaves to IDLE when LTSSM_ElecIdleReq_P0=0; TXELECIDLE deasserts one cycle later.
  - SKP counter is held at 0 in EIDLE and COMPL.
- SKP counter:
  - Increments in every other state.
  - At SKP_INTERVAL-1 it wraps to 0 and sets skp_pending.
  - A wrap while skp_pending=1 does not queue a second SKP.
- SKP state:
  - Sends BC(K), 1C(K), 1C(K), 1C(K).
  - Clears skp_pending on entry; pulses SkpSent with the 4th symbol.
  - Then re-evaluates the boundary.
- EIOS state:
  - Sends BC(K), 7C(K), 7C(K), 7C(K), then goes to EIDLE.
  - TXELECIDLE=1 the cycle after the last 7C.
  - If a SKP is pending at the same boundary, the SKP goes first, then EIOS.
  - A request dropped mid-EIOS still completes into EIDLE.
- COMPL state:
  - Repeats BC(K), B5(D), BC(K), 4A(D); TXCOMPLIANCE=1 with the first BC only.
  - Exit is checked only after 4A: ElecIdleReq → EIOS, Compliance=0 → IDLE, otherwise repeat.
  - skp_pending is cleared on entry to COMPL.
- Simultaneous Valid and a pending SKP at a boundary: SKP wins, DL_Ready=0.

Test Plan:
- Release RESET with ElecIdleReq=0, no data → TXELECIDLE=1 for 1 cycle post-reset, then 0; TXDATA=00/K=0 every cycle; first BC,1C,1C,1C starts at cycle SKP_INTERVAL+1 with SkpSent on the 4th symbol.
- SKP_INTERVAL=16; drive a 20-symbol packet starting 2 cycles before expiry → packet unbroken; SKP sequence immediately after the Eop symbol; DL_Ready=0 for exactly 4 cycles.
- Mid-packet DL_Valid low for 3 cycles → 3 × 00/K=0 symbols, 3 Underrun pulses, remaining packet bytes in order.
- ElecIdleReq asserted in IDLE coincident with skp_pending → BC,1C,1C,1C,BC,7C,7C,7C, then TXELECIDLE=1.
- Compliance=1 for 10 cycles → pattern BC,B5,BC,4A repeated 3 times (exit at pattern end), TXCOMPLIANCE high on cycles 1, 5, 9; no SKP inserted.
- RESET asserted during 2nd SKP symbol → outputs at reset values in the same cycle; after release, sequence restarts from EIDLE/IDLE with counter 0.

Source files
------------

// File: rtl/pciexp_tx_sched.sv
// PCIe transmit symbol scheduler: picks one symbol per PCLK250 cycle from link-layer
// data, SKP/EIOS ordered sets, the compliance pattern or logical idle.
module pciexp_tx_sched #(
    parameter int unsigned SKP_INTERVAL = 1180
) (
    input  logic       PCLK250,
    input  logic       RESET,
    input  logic       LTSSM_ElecIdleReq_P0,
    input  logic       CNTL_Compliance_P0,
    input  logic       DL_Valid_P0,
    input  logic [7:0] DL_Data_P0,
    input  logic       DL_DataK_P0,
    input  logic       DL_Eop_P0,
    output logic       DL_Ready,
    output logic [7:0] TXDATA,
    output logic       TXDATAK,
    output logic       TXELECIDLE,
    output logic       TXCOMPLIANCE,
    output logic       SkpSent,
    output logic       Underrun
);

    typedef enum logic [2:0] {
        EIDLE = 3'd0,
        IDLE  = 3'd1,
        DATA  = 3'd2,
        SKP   = 3'd3,
        EIOS  = 3'd4,
        COMPL = 3'd5
    } state_t;

    localparam logic [7:0] SYM_COM  = 8'hBC;
    localparam logic [7:0] SYM_SKP  = 8'h1C;
    localparam logic [7:0] SYM_IDL  = 8'h7C;
    localparam logic [7:0] SYM_D215 = 8'hB5;
    localparam logic [7:0] SYM_D102 = 8'h4A;
    localparam logic [11:0] SKP_LAST = 12'(SKP_INTERVAL - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [11:0] skp_cnt_q;
    logic        skp_pending_q;
    logic        in_pkt_q, in_pkt_d;
    logic        pend_clr, cnt_clr, skp_wrap;

    logic [7:0]  sym_data;
    logic        sym_k, sym_ei, sym_cp, sym_skp, sym_un, ready_c;

    // Compliance pattern lookup; only the first COM carries the disparity flag
    function automatic logic [9:0] compl_sym(input logic [1:0] idx);
        case (idx)
            2'd0:    compl_sym = {SYM_COM, 1'b1, 1'b1};
            2'd1:    compl_sym = {SYM_D215, 1'b0, 1'b0};
            2'd2:    compl_sym = {SYM_COM, 1'b1, 1'b0};
            default: compl_sym = {SYM_D102, 1'b0, 1'b0};
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        in_pkt_d = in_pkt_q;
        sym_data = 8'h00;
        sym_k    = 1'b0;
        sym_ei   = 1'b0;
        sym_cp   = 1'b0;
        sym_skp  = 1'b0;
        sym_un   = 1'b0;
        ready_c  = 1'b0;
        pend_clr = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            EIDLE: begin
                sym_ei = 1'b1;
                if (!LTSSM_ElecIdleReq_P0)
                    state_d = IDLE;
            end
            SKP: begin
                sym_data = SYM_SKP;
                sym_k    = 1'b1;
                idx_d    = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    sym_skp = 1'b1;
                    state_d = IDLE;
                end
            end
            EIOS: begin
                sym_data = (idx_q == 2'd0) ? SYM_COM : SYM_IDL;
                sym_k    = 1'b1;
                idx_d    = idx_q + 2'd1;
                if (idx_q == 2'd3)
                    state_d = EIDLE;
            end
            COMPL: begin
                {sym_data, sym_k, sym_cp} = compl_sym(idx_q);
                idx_d = idx_q + 2'd1;
                // Exit only at the end of a full four-symbol pattern
                if (idx_q == 2'd3) begin
                    if (LTSSM_ElecIdleReq_P0)
                        state_d = EIOS;
                    else if (!CNTL_Compliance_P0)
                        state_d = IDLE;
                end
            end
            IDLE, DATA: begin
                if (in_pkt_q) begin
                    ready_c = 1'b1;
                    if (DL_Valid_P0) begin
                        sym_data = DL_Data_P0;
                        sym_k    = DL_DataK_P0;
                        in_pkt_d = !DL_Eop_P0;
                    end else begin
                        sym_un = 1'b1;
                    end
                end else if (skp_pending_q) begin
                    sym_data = SYM_COM;
                    sym_k    = 1'b1;
                    state_d  = SKP;
                    idx_d    = 2'd1;
                    pend_clr = 1'b1;
                end else if (LTSSM_ElecIdleReq_P0) begin
                    sym_data = SYM_COM;
                    sym_k    = 1'b1;
                    state_d  = EIOS;
                    idx_d    = 2'd1;
                end else if (CNTL_Compliance_P0) begin
                    {sym_data, sym_k, sym_cp} = compl_sym(2'd0);
                    state_d  = COMPL;
                    idx_d    = 2'd1;
                    pend_clr = 1'b1;
                    cnt_clr  = 1'b1;
                end else begin
                    ready_c = 1'b1;
                    if (DL_Valid_P0) begin
                        sym_data = DL_Data_P0;
                        sym_k    = DL_DataK_P0;
                        in_pkt_d = !DL_Eop_P0;
                        state_d  = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                sym_ei  = 1'b1;
                state_d = EIDLE;
            end
        endcase
    end

    assign DL_Ready = ready_c;
    assign skp_wrap = (skp_cnt_q == SKP_LAST);

    // Control state and SKP interval tracking
    always_ff @(posedge PCLK250 or posedge RESET) begin
        if (RESET) begin
            state_q       <= EIDLE;
            idx_q         <= 2'd0;
            in_pkt_q      <= 1'b0;
            skp_cnt_q     <= 12'd0;
            skp_pending_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            in_pkt_q <= in_pkt_d;
            if (state_q == EIDLE || state_q == COMPL || cnt_clr) begin
                skp_cnt_q     <= 12'd0;
                skp_pending_q <= skp_pending_q & ~pend_clr;
            end else begin
                skp_cnt_q     <= skp_wrap ? 12'd0 : skp_cnt_q + 12'd1;
                // A wrap while a SKP is already owed is dropped, never queued
                skp_pending_q <= (skp_pending_q & ~pend_clr) | (skp_wrap & ~skp_pending_q);
            end
        end
    end

    // Registered symbol stage toward the encoder
    always_ff @(posedge PCLK250 or posedge RESET) begin
        if (RESET) begin
            TXDATA       <= 8'h00;
            TXDATAK      <= 1'b0;
            TXELECIDLE   <= 1'b1;
            TXCOMPLIANCE <= 1'b0;
            SkpSent      <= 1'b0;
            Underrun     <= 1'b0;
        end else begin
            TXDATA       <= sym_data;
            TXDATAK      <= sym_k;
            TXELECIDLE   <= sym_ei;
            TXCOMPLIANCE <= sym_cp;
            SkpSent      <= sym_skp;
            Underrun     <= sym_un;
        end
    end

endmodule

// File: tb/tb_pciexp_tx_sched.sv
// Directed scoreboard bench for pciexp_tx_sched with a 16-symbol SKP interval.
module tb_pciexp_tx_sched;

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       ei;
        logic       cp;
        logic       skp;
        logic       un;
    } tx_t;

    logic       clk;
    logic       rst;
    logic       eireq;
    logic       cmpl;
    logic       dv;
    logic [7:0] dd;
    logic       dk;
    logic       deop;
    logic       rdy;
    logic [7:0] txd;
    logic       txk;
    logic       txei;
    logic       txcp;
    logic       skps;
    logic       undr;

    int  n_assert = 0;
    int  n_fail   = 0;
    tx_t exp_q[$];

    pciexp_tx_sched #(.SKP_INTERVAL(16)) dut (
        .PCLK250              (clk),
        .RESET                (rst),
        .LTSSM_ElecIdleReq_P0 (eireq),
        .CNTL_Compliance_P0   (cmpl),
        .DL_Valid_P0          (dv),
        .DL_Data_P0           (dd),
        .DL_DataK_P0          (dk),
        .DL_Eop_P0            (deop),
        .DL_Ready             (rdy),
        .TXDATA               (txd),
        .TXDATAK              (txk),
        .TXELECIDLE           (txei),
        .TXCOMPLIANCE         (txcp),
        .SkpSent              (skps),
        .Underrun             (undr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic tx_t mk(input logic [7:0] d, input logic k, input logic ei,
                               input logic cp, input logic skp, input logic un);
        mk = {d, k, ei, cp, skp, un};
    endfunction

    function automatic tx_t sym(input logic [7:0] d, input logic k);
        sym = mk(d, k, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // One symbol time: check DL_Ready for the current decision, then the registered result
    task automatic step(input string tag, input tx_t e, input logic exp_rdy);
        tx_t got;
        tx_t want;
        #1;
        n_assert++;
        assert (rdy === exp_rdy) else begin
            n_fail++;
            $error("FAIL %s_rdy: observed %b expected %b", tag, rdy, exp_rdy);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = {txd, txk, txei, txcp, skps, undr};
        want = exp_q.pop_front();
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed d=%h k=%b ei=%b cp=%b skp=%b un=%b expected d=%h k=%b ei=%b cp=%b skp=%b un=%b",
                   tag, got.d, got.k, got.ei, got.cp, got.skp, got.un,
                   want.d, want.k, want.ei, want.cp, want.skp, want.un);
        end
    endtask

    task automatic check_reset(input string tag);
        tx_t got;
        got = {txd, txk, txei, txcp, skps, undr};
        n_assert++;
        assert (got === mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        n_assert++;
        assert (rdy === 1'b0) else begin
            n_fail++;
            $error("FAIL %s_rdy: observed %b expected 0", tag, rdy);
        end
    endtask

    // From reset release: one electrical-idle symbol, 16 idles, then the first SKP set
    task automatic boot_seq(input string tag);
        step({tag, "_ei"}, mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
        for (int i = 0; i < 16; i++)
            step({tag, "_idle"}, sym(8'h00, 1'b0), 1'b1);
        step({tag, "_skp0"}, sym(8'hBC, 1'b1), 1'b0);
        step({tag, "_skp1"}, sym(8'h1C, 1'b1), 1'b0);
        step({tag, "_skp2"}, sym(8'h1C, 1'b1), 1'b0);
        step({tag, "_skp3"}, mk(8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        eireq = 1'b0;
        cmpl  = 1'b0;
        dv    = 1'b0;
        dd    = 8'h00;
        dk    = 1'b0;
        deop  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        boot_seq("t1");

        // Packet spanning the SKP interval expiry must not be broken
        for (int i = 0; i < 9; i++)
            step("t2_pre", sym(8'h00, 1'b0), 1'b1);
        for (int i = 0; i < 20; i++) begin
            dv   = 1'b1;
            dd   = (i == 0) ? 8'hFB : (i == 19) ? 8'hFD : 8'(8'h10 + i);
            dk   = (i == 0 || i == 19);
            deop = (i == 19);
            step("t2_pkt", sym(dd, dk), 1'b1);
        end
        dd   = 8'hA5;
        dk   = 1'b0;
        deop = 1'b1;
        step("t2_skp0", sym(8'hBC, 1'b1), 1'b0);
        step("t2_skp1", sym(8'h1C, 1'b1), 1'b0);
        step("t2_skp2", sym(8'h1C, 1'b1), 1'b0);
        step("t2_skp3", mk(8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
        step("t2_next", sym(8'hA5, 1'b0), 1'b1);

        // Underrun: valid drops for three cycles inside a packet
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                dv = 1'b0;
                for (int j = 0; j < 3; j++)
                    step("t3_undr", mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
            end
            dv   = 1'b1;
            dd   = 8'(8'h50 + i);
            dk   = 1'b0;
            deop = (i == 5);
            step("t3_pkt", sym(dd, 1'b0), 1'b1);
        end
        dv   = 1'b0;
        deop = 1'b0;
        step("t3_idle", sym(8'h00, 1'b0), 1'b1);

        // Electrical idle request arriving together with an owed SKP
        eireq = 1'b1;
        step("t4_skp0", sym(8'hBC, 1'b1), 1'b0);
        step("t4_skp1", sym(8'h1C, 1'b1), 1'b0);
        step("t4_skp2", sym(8'h1C, 1'b1), 1'b0);
        step("t4_skp3", mk(8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
        step("t4_eios0", sym(8'hBC, 1'b1), 1'b0);
        for (int i = 0; i < 3; i++)
            step("t4_eios7c", sym(8'h7C, 1'b1), 1'b0);
        step("t4_ei0", mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
        step("t4_ei1", mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);

        // Compliance held for ten cycles: three full patterns
        eireq = 1'b0;
        step("t5_ei", mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
        for (int n = 0; n < 12; n++) begin
            cmpl = (n < 10);
            case (n % 4)
                0:       step("t5_com_cp", mk(8'hBC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0);
                1:       step("t5_b5", sym(8'hB5, 1'b0), 1'b0);
                2:       step("t5_com", sym(8'hBC, 1'b1), 1'b0);
                default: step("t5_4a", sym(8'h4A, 1'b0), 1'b0);
            endcase
        end
        cmpl = 1'b0;

        // Counter restarted at compliance exit: next SKP after a full interval
        for (int i = 0; i < 16; i++)
            step("t6_idle", sym(8'h00, 1'b0), 1'b1);
        step("t6_skp0", sym(8'hBC, 1'b1), 1'b0);
        step("t6_skp1", sym(8'h1C, 1'b1), 1'b0);

        // Asynchronous reset in the middle of the SKP set
        #1;
        rst = 1'b1;
        #1;
        check_reset("t6_async_rst");
        #2;
        rst = 1'b0;
        boot_seq("t6_boot");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
